// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider (ratio 2..2^CNT_W-1, odd ratios supported).
// Optional o_TICK strobe on each o_CLK rising edge when CLKDIV_TICK_EN is defined.
module clk_divider_prog #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DIV_INIT = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_EN,
  input  logic [CNT_W-1:0] i_DIV,
  input  logic             i_LOAD,
  output logic             o_CLK,
  output logic             o_PEND,
  output logic             o_RUN,
`ifdef CLKDIV_TICK_EN
  output logic             o_TICK,
`endif
  output logic [CNT_W-1:0] o_DIV
);

  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST = (DIV_INIT < 2) ? DIV_MIN : CNT_W'(DIV_INIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend;
  logic             r_clk;
  logic             r_run;
`ifdef CLKDIV_TICK_EN
  logic             r_tick;
`endif

  logic             w_last;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W:0]   w_half;
  logic             w_clk_run;
  logic [CNT_W-1:0] w_load_val;
  logic             w_apply;

  always_comb begin
    w_last     = (r_cnt == (r_div - CNT_W'(1)));
    w_cnt_inc  = w_last ? '0 : (r_cnt + CNT_W'(1));
    // High phase is ceil(D/2); the extra bit keeps D+1 from overflowing.
    w_half     = ({1'b0, r_div} + (CNT_W+1)'(1)) >> 1;
    w_clk_run  = ({1'b0, w_cnt_inc} < w_half);
    w_load_val = (i_DIV < DIV_MIN) ? DIV_MIN : i_DIV;
    w_apply    = r_pend && ((r_state == S_IDLE) || w_last);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= DIV_RST;
      r_pend_div <= DIV_RST;
      r_pend     <= 1'b0;
      r_clk      <= 1'b0;
      r_run      <= 1'b0;
`ifdef CLKDIV_TICK_EN
      r_tick     <= 1'b0;
`endif
    end else begin
      // A load coinciding with an apply edge: old pending value goes live,
      // new value stays pending.
      if (w_apply) r_div <= r_pend_div;
      if (i_LOAD) begin
        r_pend_div <= w_load_val;
        r_pend     <= 1'b1;
      end else if (w_apply) begin
        r_pend     <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_EN) begin
            r_state <= S_RUN;
            r_clk   <= 1'b1;
            r_run   <= 1'b1;
`ifdef CLKDIV_TICK_EN
            r_tick  <= 1'b1;
`endif
          end else begin
            r_clk   <= 1'b0;
            r_run   <= 1'b0;
`ifdef CLKDIV_TICK_EN
            r_tick  <= 1'b0;
`endif
          end
        end
        S_RUN, S_DRAIN: begin
          if (w_last && !i_EN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_run   <= 1'b0;
`ifdef CLKDIV_TICK_EN
            r_tick  <= 1'b0;
`endif
          end else begin
            // Drain keeps counting so no phase is ever truncated.
            r_state <= i_EN ? S_RUN : S_DRAIN;
            r_cnt   <= w_cnt_inc;
            r_clk   <= w_clk_run;
            r_run   <= 1'b1;
`ifdef CLKDIV_TICK_EN
            r_tick  <= w_last;
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_clk   <= 1'b0;
          r_run   <= 1'b0;
`ifdef CLKDIV_TICK_EN
          r_tick  <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign o_CLK  = r_clk;
  assign o_PEND = r_pend;
  assign o_RUN  = r_run;
  assign o_DIV  = r_div;
`ifdef CLKDIV_TICK_EN
  assign o_TICK = r_tick;
`endif

endmodule
